// File: rtl/axi_ar_rr_arbiter.sv
// Read-address arbiter for one downstream slave port of the AXI crossbar.
// It picks one request per grant from NUM_M upstream masters using round-robin.
// Permitted requests go to the slave through a registered AR slice.
// Denied requests go to the virtual error slave.
// It limits the number of outstanding reads and prefixes ARID with the source index.
//
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   s_ar_*  / s_ar_valid           packed per-master AR requests (master i in slice i)
//   s_ar_ready                     one-hot/zero accept, combinational in the capture cycle
//   region_read_en                 per-master read permission for this slave
//   m_ar_* / m_ar_valid/m_ar_ready forwarded AR channel, m_ar_id = {src_idx, ARID}
//   err_valid/err_id/err_len/err_ready  denied request to the virtual error slave
//   r_done                         pulse when the last beat of one read completes
//   outst_cnt                      outstanding read count (debug)
module axi_ar_rr_arbiter #(
    parameter int unsigned NUM_M     = 3,
    parameter int unsigned ADDR_W    = 14,
    parameter int unsigned ID_W      = 4,
    parameter int unsigned IDX_W     = 2,
    parameter int unsigned MAX_OUTST = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_M*ADDR_W-1:0] s_ar_addr,
    input  logic [NUM_M*8-1:0]      s_ar_len,
    input  logic [NUM_M*3-1:0]      s_ar_size,
    input  logic [NUM_M*2-1:0]      s_ar_burst,
    input  logic [NUM_M*ID_W-1:0]   s_ar_id,
    input  logic [NUM_M-1:0]        s_ar_valid,
    output logic [NUM_M-1:0]        s_ar_ready,
    input  logic [NUM_M-1:0]        region_read_en,
    output logic [ADDR_W-1:0]       m_ar_addr,
    output logic [7:0]              m_ar_len,
    output logic [2:0]              m_ar_size,
    output logic [1:0]              m_ar_burst,
    output logic [IDX_W+ID_W-1:0]   m_ar_id,
    output logic                    m_ar_valid,
    input  logic                    m_ar_ready,
    output logic                    err_valid,
    output logic [IDX_W+ID_W-1:0]   err_id,
    output logic [7:0]              err_len,
    input  logic                    err_ready,
    input  logic                    r_done,
    output logic [3:0]              outst_cnt
);

    localparam int unsigned OID_W = IDX_W + ID_W;
    localparam int unsigned SEL_W = (NUM_M > 1) ? $clog2(NUM_M) : 1;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        ERR  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr, ptr_d, src_idx, next_ptr;
    logic [ADDR_W-1:0]  addr_q;
    logic [7:0]         len_q;
    logic [2:0]         size_q;
    logic [1:0]         burst_q;
    logic [OID_W-1:0]   id_q;
    logic [CNT_W-1:0]   outst_q;

    logic [NUM_M-1:0]   elig;
    logic               cnt_room;
    logic               found;
    logic [SEL_W-1:0]   win;
    int unsigned        cand;
    logic               capture;
    logic               cnt_inc, cnt_dec;

    // A denied request never waits for the outstanding limit.
    assign cnt_room = (outst_q < CNT_W'(MAX_OUTST));
    assign elig     = s_ar_valid & (~region_read_en | {NUM_M{cnt_room}});

    // The pointer advances past the master whose request just completed.
    assign src_idx  = id_q[OID_W-1 -: IDX_W];
    assign next_ptr = (src_idx == IDX_W'(NUM_M - 1)) ? '0 : src_idx + IDX_W'(1);

    // Round-robin search upward from rr_ptr, wrapping at NUM_M-1.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = 0;
        for (int k = 0; k < NUM_M; k++) begin
            cand = (32'(rr_ptr) + 32'(k)) % NUM_M;
            if (!found && elig[SEL_W'(cand)]) begin
                found = 1'b1;
                win   = SEL_W'(cand);
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rr_ptr  <= '0;
        end else begin
            state_q <= state_d;
            rr_ptr  <= ptr_d;
        end
    end

    // Next-state logic and the combinational accept
    always_comb begin
        state_d    = state_q;
        ptr_d      = rr_ptr;
        capture    = 1'b0;
        s_ar_ready = '0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    capture         = 1'b1;
                    s_ar_ready[win] = 1'b1;
                    state_d         = region_read_en[win] ? FWD : ERR;
                end
            end
            FWD: begin
                if (m_ar_ready) begin
                    state_d = IDLE;
                    ptr_d   = next_ptr;
                end
            end
            ERR: begin
                if (err_ready) begin
                    state_d = IDLE;
                    ptr_d   = next_ptr;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output slice. It is loaded only in the capture cycle, so the payload holds until the handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            len_q   <= '0;
            size_q  <= '0;
            burst_q <= '0;
            id_q    <= '0;
        end else if (capture) begin
            addr_q  <= s_ar_addr[win*ADDR_W +: ADDR_W];
            len_q   <= s_ar_len[win*8 +: 8];
            size_q  <= s_ar_size[win*3 +: 3];
            burst_q <= s_ar_burst[win*2 +: 2];
            id_q    <= {IDX_W'(win), s_ar_id[win*ID_W +: ID_W]};
        end
    end

    // Outstanding reads. r_done at zero is ignored.
    assign cnt_inc = (state_q == FWD) && m_ar_ready;
    assign cnt_dec = r_done && (outst_q != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outst_q <= '0;
        end else begin
            case ({cnt_inc, cnt_dec})
                2'b10:   outst_q <= outst_q + CNT_W'(1);
                2'b01:   outst_q <= outst_q - CNT_W'(1);
                default: outst_q <= outst_q;
            endcase
        end
    end

    assign m_ar_valid = (state_q == FWD);
    assign err_valid  = (state_q == ERR);
    assign m_ar_addr  = addr_q;
    assign m_ar_len   = len_q;
    assign m_ar_size  = size_q;
    assign m_ar_burst = burst_q;
    assign m_ar_id    = id_q;
    assign err_id     = id_q;
    assign err_len    = len_q;
    assign outst_cnt  = outst_q;

endmodule

// File: tb/tb_axi_ar_rr_arbiter.sv
module tb_axi_ar_rr_arbiter;

    localparam int unsigned NUM_M  = 3;
    localparam int unsigned ADDR_W = 14;
    localparam int unsigned ID_W   = 4;
    localparam int unsigned IDX_W  = 2;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [NUM_M*ADDR_W-1:0] s_ar_addr;
    logic [NUM_M*8-1:0]      s_ar_len;
    logic [NUM_M*3-1:0]      s_ar_size;
    logic [NUM_M*2-1:0]      s_ar_burst;
    logic [NUM_M*ID_W-1:0]   s_ar_id;
    logic [NUM_M-1:0]        s_ar_valid;
    logic [NUM_M-1:0]        s_ar_ready;
    logic [NUM_M-1:0]        region_read_en;
    logic [ADDR_W-1:0]       m_ar_addr;
    logic [7:0]              m_ar_len;
    logic [2:0]              m_ar_size;
    logic [1:0]              m_ar_burst;
    logic [IDX_W+ID_W-1:0]   m_ar_id;
    logic                    m_ar_valid;
    logic                    m_ar_ready;
    logic                    err_valid;
    logic [IDX_W+ID_W-1:0]   err_id;
    logic [7:0]              err_len;
    logic                    err_ready;
    logic                    r_done;
    logic [3:0]              outst_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    axi_ar_rr_arbiter #(
        .NUM_M(NUM_M), .ADDR_W(ADDR_W), .ID_W(ID_W), .IDX_W(IDX_W), .MAX_OUTST(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_ar_addr(s_ar_addr), .s_ar_len(s_ar_len), .s_ar_size(s_ar_size),
        .s_ar_burst(s_ar_burst), .s_ar_id(s_ar_id), .s_ar_valid(s_ar_valid),
        .s_ar_ready(s_ar_ready), .region_read_en(region_read_en),
        .m_ar_addr(m_ar_addr), .m_ar_len(m_ar_len), .m_ar_size(m_ar_size),
        .m_ar_burst(m_ar_burst), .m_ar_id(m_ar_id), .m_ar_valid(m_ar_valid),
        .m_ar_ready(m_ar_ready), .err_valid(err_valid), .err_id(err_id),
        .err_len(err_len), .err_ready(err_ready), .r_done(r_done),
        .outst_cnt(outst_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic set_m(input int i, input logic [ADDR_W-1:0] addr, input logic [7:0] len,
                         input logic [ID_W-1:0] id);
        s_ar_addr[i*ADDR_W +: ADDR_W] = addr;
        s_ar_len[i*8 +: 8]            = len;
        s_ar_size[i*3 +: 3]           = 3'(i);
        s_ar_burst[i*2 +: 2]          = 2'b01;
        s_ar_id[i*ID_W +: ID_W]       = id;
    endtask

    // Move past the next rising edge so that inputs change away from it.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [NUM_M-1:0] onehot;
        int exp_m;
        rst_n = 1'b0;
        s_ar_addr = '0; s_ar_len = '0; s_ar_size = '0; s_ar_burst = '0; s_ar_id = '0;
        s_ar_valid = '0; region_read_en = 3'b111;
        m_ar_ready = 1'b0; err_ready = 1'b0; r_done = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_m_valid", 32'(m_ar_valid), 0);
        chk("rst_err_valid", 32'(err_valid), 0);
        chk("rst_ready", 32'(s_ar_ready), 0);
        chk("rst_outst", 32'(outst_cnt), 0);
        chk("rst_m_addr", 32'(m_ar_addr), 0);
        chk("rst_err_id", 32'(err_id), 0);
        rst_n = 1'b1;

        // Round-robin with all three masters valid. Grants go 0,1,2,0,1,2, one every two cycles.
        cyc();
        set_m(0, 14'h0000, 8'd0, 4'd8);
        set_m(1, 14'h0100, 8'd1, 4'd9);
        set_m(2, 14'h0200, 8'd2, 4'd10);
        s_ar_valid = 3'b111;
        m_ar_ready = 1'b1;
        r_done = 1'b1;
        for (int g = 0; g < 6; g++) begin
            exp_m = g % 3;
            onehot = 3'(1 << exp_m);
            @(negedge clk);
            chk($sformatf("rr_ready_%0d", g), 32'(s_ar_ready), 32'(onehot));
            cyc();
            @(negedge clk);
            chk($sformatf("rr_valid_%0d", g), 32'(m_ar_valid), 1);
            chk($sformatf("rr_id_%0d", g), 32'(m_ar_id), 32'({2'(exp_m), 4'(8 + exp_m)}));
            cyc();
        end
        s_ar_valid = '0;
        m_ar_ready = 1'b0;
        @(negedge clk);
        chk("rr_outst_tail", 32'(outst_cnt), 1);
        cyc();
        r_done = 1'b0;
        @(negedge clk);
        chk("rr_outst_drain", 32'(outst_cnt), 0);

        // Single permitted request from master 0.
        cyc();
        set_m(0, 14'h0100, 8'd3, 4'd5);
        s_ar_valid = 3'b001;
        @(negedge clk);
        chk("t1_ready", 32'(s_ar_ready), 32'(3'b001));
        chk("t1_no_valid_yet", 32'(m_ar_valid), 0);
        cyc();
        s_ar_valid = '0;
        @(negedge clk);
        chk("t1_valid", 32'(m_ar_valid), 1);
        chk("t1_id", 32'(m_ar_id), 32'(6'h05));
        chk("t1_addr", 32'(m_ar_addr), 32'h0100);
        chk("t1_len", 32'(m_ar_len), 3);
        chk("t1_burst", 32'(m_ar_burst), 1);
        cyc();
        m_ar_ready = 1'b1;
        @(negedge clk);
        chk("t1_hold", 32'(m_ar_valid), 1);
        cyc();
        m_ar_ready = 1'b0;
        @(negedge clk);
        chk("t1_done", 32'(m_ar_valid), 0);
        chk("t1_outst", 32'(outst_cnt), 1);
        cyc();
        r_done = 1'b1;
        cyc();
        r_done = 1'b0;
        @(negedge clk);
        chk("t1_outst_clr", 32'(outst_cnt), 0);

        // Denied request from master 1 goes to the error slave.
        cyc();
        region_read_en = 3'b101;
        set_m(1, 14'h0155, 8'd7, 4'd2);
        s_ar_valid = 3'b010;
        @(negedge clk);
        chk("t3_ready", 32'(s_ar_ready), 32'(3'b010));
        cyc();
        s_ar_valid = '0;
        set_m(1, 14'h0000, 8'd0, 4'd0);
        @(negedge clk);
        chk("t3_err_valid", 32'(err_valid), 1);
        chk("t3_err_id", 32'(err_id), 32'(6'h12));
        chk("t3_err_len", 32'(err_len), 7);
        chk("t3_m_valid", 32'(m_ar_valid), 0);
        cyc();
        @(negedge clk);
        chk("t3_err_hold", 32'(err_valid), 1);
        chk("t3_err_id_hold", 32'(err_id), 32'(6'h12));
        cyc();
        err_ready = 1'b1;
        cyc();
        err_ready = 1'b0;
        @(negedge clk);
        chk("t3_err_done", 32'(err_valid), 0);
        chk("t3_outst", 32'(outst_cnt), 0);

        // Outstanding limit: master 2 fills the count to 4 and then stalls.
        cyc();
        region_read_en = 3'b111;
        set_m(2, 14'h0222, 8'd4, 4'd6);
        s_ar_valid = 3'b100;
        m_ar_ready = 1'b1;
        repeat (8) cyc();
        @(negedge clk);
        chk("t4_outst_full", 32'(outst_cnt), 4);
        chk("t4_stall", 32'(s_ar_ready), 0);
        cyc();
        region_read_en = 3'b110;
        err_ready = 1'b1;
        set_m(0, 14'h0011, 8'd1, 4'd3);
        s_ar_valid = 3'b101;
        @(negedge clk);
        chk("t4_deny_ready", 32'(s_ar_ready), 32'(3'b001));
        cyc();
        s_ar_valid = 3'b100;
        @(negedge clk);
        chk("t4_err_valid", 32'(err_valid), 1);
        chk("t4_err_id", 32'(err_id), 32'(6'h03));
        cyc();
        @(negedge clk);
        chk("t4_still_stall", 32'(s_ar_ready), 0);
        chk("t4_outst_kept", 32'(outst_cnt), 4);
        cyc();
        r_done = 1'b1;
        @(negedge clk);
        chk("t4_stall_rdone", 32'(s_ar_ready), 0);
        cyc();
        r_done = 1'b0;
        @(negedge clk);
        chk("t4_outst_dec", 32'(outst_cnt), 3);
        chk("t4_capture", 32'(s_ar_ready), 32'(3'b100));
        cyc();
        s_ar_valid = '0;
        r_done = 1'b1;
        @(negedge clk);
        chk("t5_valid", 32'(m_ar_valid), 1);
        chk("t5_id", 32'(m_ar_id), 32'(6'h26));
        cyc();
        r_done = 1'b0;
        m_ar_ready = 1'b0;
        @(negedge clk);
        chk("t5_outst_same", 32'(outst_cnt), 3);
        chk("t5_done", 32'(m_ar_valid), 0);
        cyc();
        r_done = 1'b1;
        repeat (4) cyc();
        r_done = 1'b0;
        @(negedge clk);
        chk("t5_sat_zero", 32'(outst_cnt), 0);

        // Reset while FWD waits on the slave.
        cyc();
        region_read_en = 3'b111;
        err_ready = 1'b0;
        set_m(1, 14'h0333, 8'd2, 4'd1);
        s_ar_valid = 3'b010;
        m_ar_ready = 1'b1;
        cyc();
        s_ar_valid = '0;
        cyc();
        set_m(2, 14'h0444, 8'd5, 4'd7);
        s_ar_valid = 3'b100;
        m_ar_ready = 1'b0;
        cyc();
        s_ar_valid = '0;
        @(negedge clk);
        chk("t6_pre_valid", 32'(m_ar_valid), 1);
        chk("t6_pre_outst", 32'(outst_cnt), 1);
        chk("t6_pre_ptr", 32'(dut.rr_ptr), 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_valid", 32'(m_ar_valid), 0);
        chk("t6_async_addr", 32'(m_ar_addr), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_state", 32'(dut.state_q), 0);
        chk("t6_ptr", 32'(dut.rr_ptr), 0);
        chk("t6_outst", 32'(outst_cnt), 0);
        chk("t6_valid_after", 32'(m_ar_valid), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
